aes_stim_driver: RTL
====================

// Module: aes_stim_driver
// PURPOSE
//  Stimulus side of the AES-128 verify platform, feeding the chip-side scoreboard.
//  - Reads {key, plaintext, expected ciphertext} vectors from a synchronous vector ROM.
//  - Drives key/plaintext into the chip with a valid/ready handshake.
//  - Queues each expected ciphertext in an in-order FIFO; the scoreboard pops it when it
//    checks the chip's result.
// PARAMETERS
//  NUM_VEC    16  number of vectors per run (1..2**ADDR_W)
//  ADDR_W     4   vector ROM address width
//  EXP_DEPTH  4   expected-ciphertext FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1    system clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    1-cycle pulse: begin a run (ignored unless IDLE)
//  busy       out  1    high from accepted start until done
//  done       out  1    1-cycle pulse: all vectors sent and FIFO drained
//  sent_cnt   out  ADDR_W+1  vectors accepted by chip in current run
//  rom_addr   out  ADDR_W    vector ROM address
//  rom_key    in   128  ROM key, valid 1 cycle after rom_addr
//  rom_pt     in   128  ROM plaintext, same timing
//  rom_ct     in   128  ROM expected ciphertext, same timing
//  chip_key   out  128  key to chip
//  chip_pt    out  128  plaintext to chip
//  chip_valid out  1    chip_key/chip_pt valid
//  chip_ready in   1    chip accepts; transfer when chip_valid&chip_ready
//  exp_valid  out  1    FIFO non-empty
//  exp_ct     out  128  FIFO head (expected ciphertext)
//  exp_ready  in   1    scoreboard pop; pop when exp_valid&exp_ready
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, counters 0. Reset mid-run aborts; no done.
//  FSM states:
//   IDLE  -> FETCH on start; clears sent_cnt and rom_addr; busy=1 from the next cycle.
//   FETCH -> WAIT; rom_addr already holds the current index.
//   WAIT  -> LOAD (1-cycle ROM latency).
//   LOAD  - register rom_key/pt/ct into output regs, then -> SEND.
//   SEND  - chip_valid=1; chip_key/pt held stable until handshake.
//           On handshake: push ct into FIFO, sent_cnt++, chip_valid=0 next cycle.
//           Then -> FETCH with rom_addr+1 if sent_cnt+1<NUM_VEC, else -> DRAIN.
//   DRAIN -> DONE when FIFO empty.
//   DONE  - done=1 for 1 cycle, busy=0 -> IDLE.
//  Backpressure:
//   - FIFO full in SEND: chip_valid is forced 0 (stall) until a pop frees a slot.
//     A push never overflows.
//   - Push and pop in the same cycle: allowed; count is unchanged. Full+pop+push is legal.
//  FIFO:
//   - Pop when empty is ignored. Order is strictly in send order.
//   - Pointers wrap modulo EXP_DEPTH; count width is log2(EXP_DEPTH)+1.
//   - exp_ct is valid combinationally from the head entry whenever exp_valid=1.
//  start while busy is ignored. After the last vector, rom_addr does not wrap; it holds.
//  Latency: start to first chip_valid = 4 cycles (IDLE,FETCH,WAIT,LOAD).
//   Min 4 cycles per vector when chip_ready=1.
// TESTING
//  1 Reset: assert rst_n=0 mid-SEND -> all outputs 0, FIFO empty; re-start runs from addr 0.
//  2 NUM_VEC=4, chip_ready=1, exp_ready=1 -> 4 handshakes at addr 0..3, exp_ct order
//    matches rom_ct 0..3, done pulse once, sent_cnt=4.
//  3 exp_ready=0, EXP_DEPTH=4, NUM_VEC=6 -> chip_valid stalls after 4th push.
//    Release exp_ready -> remaining 2 sent, no loss or duplication.
//  4 chip_ready low 10 cycles in SEND -> chip_key/pt/valid stable throughout.
//    Single push on the eventual handshake.
//  5 FIFO full, push and pop same cycle -> count stays 4, head advances by one entry.
//  6 start pulsed while busy -> ignored. FIPS-197 vector (key 000102..0f,
//    pt 00112233..ff) -> exp_ct=69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_stim_driver.sv
// AES-128 verify-platform stimulus driver: walks a synchronous vector ROM, hands key/plaintext
// to the chip over valid/ready and queues the expected ciphertexts for the scoreboard in order.
module aes_stim_driver #(
  parameter int NUM_VEC   = 16,
  parameter int ADDR_W    = 4,
  parameter int EXP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sent_cnt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [127:0]      rom_key,
  input  logic [127:0]      rom_pt,
  input  logic [127:0]      rom_ct,
  output logic [127:0]      chip_key,
  output logic [127:0]      chip_pt,
  output logic              chip_valid,
  input  logic              chip_ready,
  output logic              exp_valid,
  output logic [127:0]      exp_ct,
  input  logic              exp_ready
);

  localparam int DATA_W = 128;
  localparam int PTR_W  = $clog2(EXP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(EXP_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_SEND, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   key_p0;
  logic [DATA_W-1:0]   pt_p0;
  logic [DATA_W-1:0]   ct_p0;
  logic                vld_p0;

  logic [DATA_W-1:0]   fifo_mem [EXP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_full;
  logic                push;
  logic                pop;

  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign exp_valid = (fifo_cnt != '0);
  assign exp_ct    = exp_valid ? fifo_mem[rd_ptr] : '0;
  assign pop       = exp_valid & exp_ready;
  // A full FIFO stalls the chip side, unless a pop in the same cycle frees the slot.
  assign chip_valid = vld_p0 & (~fifo_full | pop);
  assign push       = chip_valid & chip_ready;
  assign chip_key   = key_p0;
  assign chip_pt    = pt_p0;

  // Control FSM and chip-facing output stage (_p0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= '0;
      rom_addr <= '0;
      key_p0   <= '0;
      pt_p0    <= '0;
      vld_p0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_FETCH;
            busy     <= 1'b1;
            sent_cnt <= '0;
            rom_addr <= '0;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT:  state_q <= S_LOAD;
        S_LOAD: begin
          key_p0  <= rom_key;
          pt_p0   <= rom_pt;
          vld_p0  <= 1'b1;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (push) begin
            vld_p0   <= 1'b0;
            sent_cnt <= sent_cnt + (ADDR_W+1)'(1);
            if (sent_cnt < LAST_IDX) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state_q  <= S_FETCH;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!exp_valid) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Expected-ciphertext staging and FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) ct_p0 <= rom_ct;
    if (push) fifo_mem[wr_ptr] <= ct_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
